egress_arbiter: RTL and testbench

//  Shares one switch egress port among NUM_REQ request buffers (one per ingress port).

---
 rtl/egress_arbiter_pkg.sv | 23 ++
 rtl/egress_arbiter_rr_picker.sv | 36 +++
 rtl/egress_arbiter.sv | 148 ++++++++++++++
 tb/tb_egress_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// egress_arbiter_pkg : shared types and helpers for the switch egress arbiters
// Revision 1.0 - initial release
// ============================================================================
package egress_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Number of consecutive starved cycles tolerated before a grant is revoked.
  function automatic int stall_limit(input int ctr_width);
    return (1 << ctr_width) - 1;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/egress_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// egress_arbiter_rr_picker : combinational round-robin pick, first request at
//   or after ptr_i (modulo NUM_REQ); returns one-hot, index and found flag.
// Revision 1.0 - initial release
// ============================================================================
module egress_arbiter_rr_picker
  import egress_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               found_o
);

  // Scan farthest offset first so the nearest requester overwrites the result.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[wrap_add(int'(ptr_i), k, NUM_REQ)]) begin
        found_o = 1'b1;
        pick_o  = '0;
        pick_o[wrap_add(int'(ptr_i), k, NUM_REQ)] = 1'b1;
        idx_o   = PTR_W'(wrap_add(int'(ptr_i), k, NUM_REQ));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// egress_arbiter : frame-granular round-robin arbiter sharing one egress lane
//   among NUM_REQ request buffers. Optional macro ARB_TIMEOUT_EN revokes a
//   grant whose owner starves the lane for 2**TIMEOUT_CTR_WIDTH-1 cycles.
// Revision 1.0 - initial release
// ============================================================================
module egress_arbiter
  import egress_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH        = 20,
  parameter int TIMEOUT_CTR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          egress_valid,
  output logic [DATA_WIDTH-1:0]         egress_data,
  output logic                          egress_last,
  input  logic                          egress_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          abort
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   rr_next;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic               stall_hit;

  egress_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign rr_next = PTR_W'(wrap_add(int'(gidx_q), 1, NUM_REQ));
  assign grant   = grant_q;
  assign busy    = (state_q == ARB_GRANT);

`ifdef ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_LAST =
    TIMEOUT_CTR_WIDTH'(stall_limit(TIMEOUT_CTR_WIDTH) - 1);

  logic [TIMEOUT_CTR_WIDTH-1:0] stall_ctr_q, stall_ctr_d;
  logic                         handshake;

  assign handshake = egress_valid & egress_ready;
  // Revoke in the cycle the starved count reaches the limit.
  assign stall_hit = (state_q == ARB_GRANT) && !req_valid[gidx_q] && (stall_ctr_q == STALL_LAST);

  always_comb begin
    stall_ctr_d = stall_ctr_q;
    if (state_q != ARB_GRANT || stall_hit || handshake) begin
      stall_ctr_d = '0;
    end else if (!req_valid[gidx_q] && stall_ctr_q != STALL_LAST) begin
      stall_ctr_d = stall_ctr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_ctr_q <= '0;
    end else begin
      stall_ctr_q <= stall_ctr_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CTR_WIDTH > 0);
  assign stall_hit          = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    egress_valid = 1'b0;
    egress_data  = '0;
    egress_last  = 1'b0;
    req_ready    = '0;
    abort        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      ARB_GRANT: begin
        if (stall_hit) begin
          abort    = 1'b1;
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end else begin
          egress_valid = req_valid[gidx_q];
          egress_data  = req_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
          egress_last  = req_last[gidx_q];
          req_ready    = grant_q & {NUM_REQ{egress_ready}};
          if (egress_valid && egress_ready && egress_last) begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_egress_arbiter.sv
`default_nettype none
// ============================================================================
// tb_egress_arbiter : directed + random stimulus against a frame-level
//   reference model of the round-robin egress arbiter (honours ARB_TIMEOUT_EN).
// Revision 1.0 - initial release
// ============================================================================
module tb_egress_arbiter;

  localparam int N     = 4;
  localparam int DW    = 20;
  localparam int TW    = 3;
  localparam int LIMIT = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            egress_valid;
  logic [DW-1:0]   egress_data;
  logic            egress_last;
  logic            egress_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            abort;

  always #5 clk = ~clk;

  egress_arbiter #(
    .NUM_REQ           (N),
    .DATA_WIDTH        (DW),
    .TIMEOUT_CTR_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .egress_valid (egress_valid),
    .egress_data  (egress_data),
    .egress_last  (egress_last),
    .egress_ready (egress_ready),
    .grant        (grant),
    .busy         (busy),
    .abort        (abort)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: owner index (-1 idle), round-robin pointer, starved cycles.
  int m_owner, m_ptr, m_stall;
  bit in_reset;

  // Requester sources: beats left in current frame, forced gap, reload length.
  int            len_left   [N];
  bit            gap        [N];
  int            reload_len [N];
  int            bubble_pct;
  logic [DW-1:0] dat        [N];

  int   dut_served[$];
  int   abort_seen;
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int served_at(input int i);
    if (i < dut_served.size()) return dut_served[i];
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (len_left[i] > 0) && !gap[i] && (int'($urandom_range(99, 0)) >= bubble_pct);
      req_last[i]  = (len_left[i] == 1);
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      len_left[i]   = 0;
      gap[i]        = 1'b0;
      reload_len[i] = 0;
      dat[i]        = DW'($urandom);
    end
    bubble_pct = 0;
    drive();
  endtask

  task automatic cycle();
    logic [N-1:0]  e_grant, e_ready;
    logic          e_valid, e_last, e_abort, e_busy, hs;
    logic [DW-1:0] e_data;
    bit            found;
    e_grant = '0; e_ready = '0; e_valid = 1'b0; e_last = 1'b0;
    e_abort = 1'b0; e_busy = 1'b0; e_data = '0;
    @(negedge clk);
    if (!in_reset && m_owner >= 0) begin
      e_grant = N'(1) << m_owner;
      e_busy  = 1'b1;
`ifdef ARB_TIMEOUT_EN
      e_abort = !req_valid[m_owner] && (m_stall == LIMIT - 1);
`endif
      if (!e_abort) begin
        e_valid = req_valid[m_owner];
        e_data  = dat[m_owner];
        e_last  = req_last[m_owner];
        e_ready = egress_ready ? e_grant : '0;
      end
    end
    chk("grant",     32'(grant),        32'(e_grant));
    chk("busy",      32'(busy),         32'(e_busy));
    chk("abort",     32'(abort),        32'(e_abort));
    chk("e_valid",   32'(egress_valid), 32'(e_valid));
    chk("e_data",    32'(egress_data),  32'(e_data));
    chk("e_last",    32'(egress_last),  32'(e_last));
    chk("req_ready", 32'(req_ready),    32'(e_ready));
    if (abort) abort_seen++;
    if (prev_grant == '0 && grant != '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) dut_served.push_back(i);
    end
    prev_grant = grant;
    hs = e_valid && egress_ready;
    @(posedge clk);
    #1;
    if (!in_reset) begin
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % N;
            m_stall = 0;
          end
        end
      end else if (e_abort || (hs && e_last)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_stall = 0;
      end else if (hs) begin
        m_stall = 0;
      end else if (!req_valid[m_owner]) begin
        m_stall++;
      end
      for (int i = 0; i < N; i++) begin
        if (hs && e_grant[i]) begin
          len_left[i]--;
          dat[i] = DW'($urandom);
          if (len_left[i] == 0 && reload_len[i] != 0)
            len_left[i] = (reload_len[i] < 0) ? int'($urandom_range(4, 1)) : reload_len[i];
        end
      end
    end
    drive();
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_reset = 1'b1;
    m_owner  = -1;
    m_ptr    = 0;
    m_stall  = 0;
    repeat (2) cycle();
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    in_reset     = 1'b1;
    egress_ready = 1'b0;
    prev_grant   = '0;
    abort_seen   = 0;
    m_owner = -1; m_ptr = 0; m_stall = 0;
    clear_sources();

    // Reset held with every requester asserting, then 1-beat frames drain in order.
    for (int i = 0; i < N; i++) len_left[i] = 1;
    drive();
    apply_reset();
    egress_ready = 1'b1;
    repeat (8) cycle();

    // Single 3-beat frame from requester 2; the pointer then favours 3.
    len_left[2] = 3;
    drive();
    repeat (4) cycle();
    for (int i = 0; i < N; i++) len_left[i] = 1;
    drive();
    cycle();
    chk("rr_after_single", 32'(grant), 32'h8);
    repeat (8) cycle();

    // Fairness with constant requests and 2-beat frames.
    clear_sources();
    apply_reset();
    dut_served.delete();
    for (int i = 0; i < N; i++) begin
      len_left[i]   = 2;
      reload_len[i] = 2;
    end
    drive();
    repeat (20) cycle();
    chk("fair_0", 32'(served_at(0)), 32'd0);
    chk("fair_1", 32'(served_at(1)), 32'd1);
    chk("fair_2", 32'(served_at(2)), 32'd2);
    chk("fair_3", 32'(served_at(3)), 32'd3);
    chk("fair_4", 32'(served_at(4)), 32'd0);
    for (int i = 0; i < N; i++) reload_len[i] = 0;
    repeat (16) cycle();

    // Grant hold: requester 0 arrives while 1 owns the lane.
    clear_sources();
    apply_reset();
    dut_served.delete();
    len_left[1] = 4;
    drive();
    repeat (2) cycle();
    len_left[0] = 2;
    drive();
    repeat (10) cycle();
    chk("hold_first",  32'(served_at(0)), 32'd1);
    chk("hold_second", 32'(served_at(1)), 32'd0);

    // Backpressure mid-frame.
    abort_seen = 0;
    len_left[3] = 4;
    drive();
    repeat (3) cycle();
    egress_ready = 1'b0;
    repeat (5) cycle();
    egress_ready = 1'b1;
    repeat (6) cycle();
    chk("bp_no_abort", 32'(abort_seen), 32'd0);

    // Starved owner with another requester pending.
    abort_seen = 0;
    dut_served.delete();
    len_left[2] = 3;
    drive();
    repeat (2) cycle();
    gap[2]      = 1'b1;
    len_left[0] = 1;
    drive();
    repeat (10) cycle();
`ifdef ARB_TIMEOUT_EN
    chk("to_abort_count", 32'(abort_seen),    32'd1);
    chk("to_next_served", 32'(served_at(1)),  32'd0);
`else
    chk("to_abort_count", 32'(abort_seen),    32'd0);
    chk("to_grant_held",  32'(grant),         32'h4);
`endif
    gap[2] = 1'b0;
    drive();
    repeat (12) cycle();

    // Asynchronous reset in the middle of a frame.
    clear_sources();
    len_left[1] = 5;
    drive();
    repeat (3) cycle();
    reset_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant),     32'h0);
    chk("midrst_busy",  32'(busy),      32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    clear_sources();
    apply_reset();

    // Random traffic: bubbles, random frame lengths, random backpressure.
    for (int i = 0; i < N; i++) reload_len[i] = -1;
    bubble_pct = 30;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        for (int i = 0; i < N; i++)
          if (len_left[i] == 0 && ($urandom_range(1, 0) == 1)) len_left[i] = int'($urandom_range(4, 1));
      end
      egress_ready = ($urandom_range(3, 0) != 0);
      drive();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
